muldiv_sequencer: RTL

//  Multi-cycle sequencer for RV32M ops (OP=0110011, funct7=0000001) in the EX stage.

---
 rtl/muldiv_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M execution unit for the EX stage.
// Runs a 1-bit/cycle shift-add multiplier or restoring divider on operand
// magnitudes, applies the result sign at the end, stalls the pipeline while
// busy and counts completed M-ops. Divide-by-zero and signed overflow skip
// the iterations and complete one cycle after accept.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_op_a,
    input  logic [XLEN-1:0]  i_op_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic [XLEN-1:0]  o_result,
    output logic [CNT_W-1:0] o_op_cnt
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIN  = 2'b11
    } state_t;

    // Two's complement negation at operand width.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Two's complement negation at product width.
    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
        return ~v + (2*XLEN)'(1);
    endfunction

    state_t              state_r, state_next_s;
    logic [1:0]          funct3_r;
    logic [XLEN-1:0]     a_mag_r, b_mag_r;
    logic                neg_r, rem_neg_r;
    logic [CW-1:0]       cnt_r;
    logic [2*XLEN-1:0]   prod_r;
    logic [XLEN-1:0]     result_r;
    logic [CNT_W-1:0]    op_cnt_r;

    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s;
    logic                div_zero_s, div_ovf_s, fast_s, accept_s;
    logic [XLEN-1:0]     fast_result_s;
    state_t              accept_target_s;

    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN-1:0]   mul_next_s;
    logic [XLEN:0]       div_trial_s;
    logic [2*XLEN-1:0]   div_next_s;
    logic [2*XLEN-1:0]   prod_signed_s;
    logic [XLEN-1:0]     final_result_s;

    // Operand signedness per funct3.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (i_funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            3'b010: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign a_neg_s    = a_signed_s & i_op_a[XLEN-1];
    assign b_neg_s    = b_signed_s & i_op_b[XLEN-1];
    assign a_mag_s    = a_neg_s ? neg_x(i_op_a) : i_op_a;
    assign b_mag_s    = b_neg_s ? neg_x(i_op_b) : i_op_b;
    assign div_zero_s = i_funct3[2] & (i_op_b == '0);
    assign div_ovf_s  = i_funct3[2] & ~i_funct3[0] & (i_op_a == MIN_NEG) & (i_op_b == '1);
    assign fast_s     = div_zero_s | div_ovf_s;

    // Results for the ops that complete without iterating.
    always_comb begin
        fast_result_s = '0;
        if (div_zero_s) begin
            fast_result_s = i_funct3[1] ? i_op_a : '1;
        end else begin
            fast_result_s = i_funct3[1] ? '0 : i_op_a;
        end
    end

    assign accept_target_s = fast_s ? ST_FIN : (i_funct3[2] ? ST_DIV : ST_MUL);

    // One iteration of each engine; prod_r holds {acc, multiplier} or {rem, dividend/quotient}.
    assign mul_sum_s   = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, (prod_r[0] ? a_mag_r : '0)};
    assign mul_next_s  = {mul_sum_s, prod_r[XLEN-1:1]};
    assign div_trial_s = prod_r[2*XLEN-1:XLEN-1] - {1'b0, b_mag_r};
    assign div_next_s  = div_trial_s[XLEN] ? {prod_r[2*XLEN-2:0], 1'b0}
                                           : {div_trial_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
    assign prod_signed_s = neg_r ? neg_2x(mul_next_s) : mul_next_s;

    // Signed, word-selected result as of the final iteration.
    always_comb begin
        final_result_s = '0;
        if (state_r == ST_DIV) begin
            if (funct3_r[1]) begin
                final_result_s = rem_neg_r ? neg_x(div_next_s[2*XLEN-1:XLEN]) : div_next_s[2*XLEN-1:XLEN];
            end else begin
                final_result_s = neg_r ? neg_x(div_next_s[XLEN-1:0]) : div_next_s[XLEN-1:0];
            end
        end else begin
            if (funct3_r == 2'b00) begin
                final_result_s = prod_signed_s[XLEN-1:0];
            end else begin
                final_result_s = prod_signed_s[2*XLEN-1:XLEN];
            end
        end
    end

    // Next-state logic; flush always wins over a new request.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start && !i_flush) begin
                    accept_s     = 1'b1;
                    state_next_s = accept_target_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (i_flush) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == LAST_ITER) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_FIN: begin
                if (i_flush) begin
                    state_next_s = ST_IDLE;
                end else if (i_start) begin
                    accept_s     = 1'b1;
                    state_next_s = accept_target_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, iteration and result write on entry to FIN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            funct3_r  <= 2'b00;
            a_mag_r   <= '0;
            b_mag_r   <= '0;
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            cnt_r     <= '0;
            prod_r    <= '0;
            result_r  <= '0;
        end else if (accept_s) begin
            funct3_r  <= i_funct3[1:0];
            a_mag_r   <= a_mag_s;
            b_mag_r   <= b_mag_s;
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            cnt_r     <= '0;
            prod_r    <= i_funct3[2] ? {{XLEN{1'b0}}, a_mag_s} : {{XLEN{1'b0}}, b_mag_s};
            if (fast_s) begin
                result_r <= fast_result_s;
            end
        end else if ((state_r == ST_MUL || state_r == ST_DIV) && !i_flush) begin
            prod_r <= (state_r == ST_DIV) ? div_next_s : mul_next_s;
            cnt_r  <= cnt_r + CW'(1);
            if (cnt_r == LAST_ITER) begin
                result_r <= final_result_s;
            end
        end
    end

    // Completed-op counter; every cycle in FIN is one completed op.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_cnt_r <= '0;
        end else if (state_r == ST_FIN) begin
            op_cnt_r <= op_cnt_r + CNT_W'(1);
        end
    end

    assign o_busy   = (state_r == ST_MUL) || (state_r == ST_DIV);
    assign o_done   = (state_r == ST_FIN);
    assign o_stall  = (i_start && (state_r == ST_IDLE) && !i_flush) || o_busy;
    assign o_result = result_r;
    assign o_op_cnt = op_cnt_r;

endmodule
